ex_muldiv: RTL and testbench
============================

EX_MULDIV -- requirements
Module: ex_muldiv

Interface
REQ-001 SHALL provide parameter DATA_W, default 32: operand, HI and LO width; legal range 8..64.
REQ-002 SHALL provide parameter MUL_ITER, default 1: 1 = iterative shift-add multiplier, 0 = single-cycle multiplier.
REQ-003 SHALL provide port clk  input  1  rising-edge clock.
REQ-004 SHALL provide port rst_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL provide port start  input  1  request; sampled only in IDLE.
REQ-006 SHALL provide port op  input  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MADD, 101 MSUB; 110/111 reserved.
REQ-007 SHALL provide ports op1, op2  input  DATA_W  operands (rs, rt).
REQ-008 SHALL provide ports hi_in, lo_in  input  DATA_W  forwarded HI/LO, used by MADD/MSUB only.
REQ-009 SHALL provide port cancel  input  1  pipeline flush; aborts the operation in progress.
REQ-010 SHALL provide port stall_req  output  1  EX-stage stall request.
REQ-011 SHALL provide port busy  output  1  high whenever state is not IDLE.
REQ-012 SHALL provide ports done, hilo_wen  output  1  one-cycle result strobe; the two are identical.
REQ-013 SHALL provide ports hi_out, lo_out  output  DATA_W  result, valid when done=1.
REQ-014 SHALL provide port div_zero  output  1  high with done when a DIV/DIVU divisor is 0.

Function
REQ-015 SHALL implement a state machine with states IDLE, MUL, DIV and DONE.
REQ-016 In IDLE, start=1 with a legal op and cancel=0 SHALL latch op, op1, op2, hi_in and lo_in, then move to MUL (MULT/MULTU/MADD/MSUB) or DIV.
REQ-017 In IDLE, start with a reserved op SHALL be ignored; no stall, no done.
REQ-018 Start in any state other than IDLE SHALL be ignored.
REQ-019 With MUL_ITER=1, MUL SHALL run exactly DATA_W iterations using a counter, then go to DONE.
REQ-020 With MUL_ITER=0, MUL SHALL last one cycle.
REQ-021 DIV SHALL run a restoring radix-2 divide for exactly DATA_W cycles, then go to DONE.
REQ-022 DIV/DIVU with op2=0 SHALL go from DIV to DONE after one cycle, with hi_out=op1, lo_out all-ones and div_zero=1.
REQ-023 Signed ops SHALL operate on magnitudes and then fix the sign: quotient negative iff operand signs differ; remainder takes the dividend's sign.
REQ-024 Signed MIN/-1 SHALL give lo_out=MIN and hi_out=0, with no flag.
REQ-025 MULT/MULTU SHALL give the full 2*DATA_W-bit product as {hi_out, lo_out}.
REQ-026 MADD SHALL give {hi_in,lo_in} + signed product; MSUB SHALL give {hi_in,lo_in} - signed product; both modulo 2^(2*DATA_W), using HI/LO latched at start.
REQ-027 DIV/DIVU SHALL give lo_out=quotient and hi_out=remainder.
REQ-028 DONE SHALL last exactly one cycle with done=hilo_wen=1, then return to IDLE.
REQ-029 hi_out, lo_out and div_zero SHALL be registered and held until the next DONE.
REQ-030 Latency from the start edge to done high SHALL be: iterative MUL and DIV, DATA_W+1 cycles; MUL_ITER=0, 2 cycles; divide-by-zero, 2 cycles.
REQ-031 stall_req SHALL be combinationally high during an accepted start cycle, and high in MUL and DIV.
REQ-032 stall_req SHALL be low in DONE and in idle cycles with no accepted start.
REQ-033 cancel SHALL take priority over start and over completion; cancel=1 at an edge SHALL force IDLE with no done and no hilo_wen.
REQ-034 cancel=1 in DONE SHALL suppress that cycle's done and hilo_wen combinationally.
REQ-035 A start on the cycle right after DONE SHALL be accepted normally; back-to-back operations are allowed.

Reset
REQ-036 rst_n=0 at a clock edge SHALL force IDLE and zero the counter.
REQ-037 Reset SHALL give done=hilo_wen=stall_req=busy=div_zero=0 and hi_out=lo_out=0.
REQ-038 Reset in the middle of an operation SHALL abort it with no done pulse.
REQ-039 Start while rst_n=0 SHALL be ignored.

Verification (DATA_W=32, MUL_ITER=1)
REQ-040 SHALL test MULT op1=0xFFFFFFFE, op2=3 -> 33 cycles later done=1, hi=0xFFFFFFFF, lo=0xFFFFFFFA; stall_req high for 33 cycles.
REQ-041 SHALL test DIV op1=0xFFFFFFF9, op2=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF, div_zero=0.
REQ-042 SHALL test DIVU op1=0x12345678, op2=0 -> done 2 cycles after start, hi=0x12345678, lo=0xFFFFFFFF, div_zero=1.
REQ-043 SHALL test MADD hi_in=0, lo_in=0xFFFFFFFF, op1=1, op2=1 -> hi=1, lo=0. Then MSUB with the same inputs -> hi=0, lo=0xFFFFFFFE.
REQ-044 SHALL test DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0. Then cancel asserted 10 cycles into a DIV -> busy=0 next cycle, no done, and the next start is accepted.
REQ-045 SHALL test rst_n=0 15 cycles into a MULTU -> all outputs 0 next cycle, no done; repeat with MUL_ITER=0 and confirm latency 2.

Source files
------------

// File: rtl/ex_muldiv_if.sv
// ex_muldiv_if: request/result bundle between the EX stage and the multiply/divide unit
interface ex_muldiv_if #(parameter int DATA_W = 32);
  logic              start, cancel, stall_req, busy, done, hilo_wen, div_zero;
  logic [2:0]        op;
  logic [DATA_W-1:0] op1, op2, hi_in, lo_in, hi_out, lo_out;
  modport master (output start, op, op1, op2, hi_in, lo_in, cancel,
                  input  stall_req, busy, done, hilo_wen, hi_out, lo_out, div_zero);
  modport slave  (input  start, op, op1, op2, hi_in, lo_in, cancel,
                  output stall_req, busy, done, hilo_wen, hi_out, lo_out, div_zero);
endinterface

// File: rtl/ex_muldiv.sv
// ex_muldiv: multi-cycle MULT/MULTU/DIV/DIVU/MADD/MSUB unit producing HI/LO
module ex_muldiv #(
  parameter int DATA_W   = 32,
  parameter int MUL_ITER = 1
) (
  input logic        clk,
  input logic        rst_n,
  ex_muldiv_if.slave bus
);
  localparam int CW = $clog2(DATA_W);
  localparam int W2 = 2 * DATA_W;
  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;
  state_t            state;
  logic [CW-1:0]     cnt;
  logic [2:0]        op_r;
  logic [DATA_W-1:0] a1, mc, hi_r, lo_r;
  logic [W2-1:0]     prod, hilo;
  logic              qneg, rneg, dz_r;
  logic              sgn, accept, is_div, last, mul_last;
  logic [DATA_W-1:0] m1, m2, q_fin, r_fin;
  logic [DATA_W:0]   mul_sum, rem_sh, diff;
  logic [W2-1:0]     mul_nx, div_nx, mul_res, mul_fin;
  always_comb begin
    sgn      = !(bus.op == 3'b001 || bus.op == 3'b011);
    is_div   = bus.op[2:1] == 2'b01;
    accept   = rst_n && state == IDLE && bus.start && !bus.cancel && bus.op <= 3'd5;
    m1       = (sgn && bus.op1[DATA_W-1]) ? -bus.op1 : bus.op1;
    m2       = (sgn && bus.op2[DATA_W-1]) ? -bus.op2 : bus.op2;
    // Multiply: upper half accumulates, lower half holds the remaining multiplier bits
    mul_sum  = {1'b0, prod[W2-1:DATA_W]} + (prod[0] ? {1'b0, mc} : '0);
    mul_nx   = (MUL_ITER != 0) ? {mul_sum, prod[DATA_W-1:1]} : W2'(mc) * W2'(prod[DATA_W-1:0]);
    // Divide: upper half is the partial remainder, lower half shifts dividend out and quotient in
    rem_sh   = {prod[W2-1:DATA_W], prod[DATA_W-1]};
    diff     = rem_sh - {1'b0, mc};
    div_nx   = diff[DATA_W] ? {rem_sh[DATA_W-1:0], prod[DATA_W-2:0], 1'b0}
                            : {diff[DATA_W-1:0], prod[DATA_W-2:0], 1'b1};
    mul_res  = qneg ? -mul_nx : mul_nx;
    mul_fin  = op_r == 3'b100 ? hilo + mul_res : op_r == 3'b101 ? hilo - mul_res : mul_res;
    q_fin    = qneg ? -div_nx[DATA_W-1:0] : div_nx[DATA_W-1:0];
    r_fin    = rneg ? -div_nx[W2-1:DATA_W] : div_nx[W2-1:DATA_W];
    last     = cnt == CW'(DATA_W - 1);
    mul_last = MUL_ITER == 0 || last;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      hi_r  <= '0;
      lo_r  <= '0;
      dz_r  <= 1'b0;
    end else if (bus.cancel) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          op_r  <= bus.op;
          a1    <= bus.op1;
          mc    <= is_div ? m2 : m1;
          prod  <= {{DATA_W{1'b0}}, is_div ? m1 : m2};
          hilo  <= {bus.hi_in, bus.lo_in};
          qneg  <= sgn && (bus.op1[DATA_W-1] ^ bus.op2[DATA_W-1]);
          rneg  <= sgn && bus.op1[DATA_W-1];
          cnt   <= '0;
          state <= is_div ? DIV : MUL;
        end
        MUL: begin
          prod <= mul_nx;
          cnt  <= cnt + 1'b1;
          if (mul_last) begin
            state        <= DONE;
            {hi_r, lo_r} <= mul_fin;
            dz_r         <= 1'b0;
          end
        end
        DIV: if (mc == '0) begin
          state <= DONE;
          hi_r  <= a1;
          lo_r  <= '1;
          dz_r  <= 1'b1;
        end else begin
          prod <= div_nx;
          cnt  <= cnt + 1'b1;
          if (last) begin
            state <= DONE;
            hi_r  <= r_fin;
            lo_r  <= q_fin;
            dz_r  <= 1'b0;
          end
        end
        DONE: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end
  assign bus.stall_req = accept || state == MUL || state == DIV;
  assign bus.busy      = state != IDLE;
  assign bus.done      = state == DONE && !bus.cancel;
  assign bus.hilo_wen  = bus.done;
  assign bus.hi_out    = hi_r;
  assign bus.lo_out    = lo_r;
  assign bus.div_zero  = dz_r;
endmodule

// File: tb/tb_ex_muldiv.sv
// tb_ex_muldiv: directed vector table plus cancel/reset/busy-start sequences for ex_muldiv
module tb_ex_muldiv;
  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;
  ex_muldiv_if #(.DATA_W(32)) b();
  ex_muldiv_if #(.DATA_W(32)) b0();
  ex_muldiv #(.DATA_W(32), .MUL_ITER(1)) dut  (.clk(clk), .rst_n(rst_n), .bus(b));
  ex_muldiv #(.DATA_W(32), .MUL_ITER(0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(b0));
  int ncmp = 0, nfail = 0;
  typedef struct {
    logic [2:0]  op;
    logic [31:0] op1, op2, hi_in, lo_in, hi, lo;
    logic        dz;
    int          lat;
  } vec_t;
  vec_t vt[13];
  task automatic chk(input string n, input string t, input logic [63:0] act, input logic [63:0] exp);
    ncmp++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s.%s: got %0h expected %0h", n, t, act, exp);
    end
  endtask
  task automatic run_op(input vec_t v, input string n);
    int lat, stl;
    b.op = v.op; b.op1 = v.op1; b.op2 = v.op2; b.hi_in = v.hi_in; b.lo_in = v.lo_in; b.start = 1'b1;
    #1;
    stl = int'(b.stall_req);
    chk(n, "stall_start", b.stall_req, 1);
    @(posedge clk); #1;
    b.start = 1'b0;
    lat = 1;
    while (!b.done && lat < 100) begin
      stl += int'(b.stall_req);
      @(posedge clk); #1;
      lat++;
    end
    chk(n, "latency", lat, v.lat);
    chk(n, "hi", b.hi_out, v.hi);
    chk(n, "lo", b.lo_out, v.lo);
    chk(n, "div_zero", b.div_zero, v.dz);
    chk(n, "hilo_wen", b.hilo_wen, 1);
    chk(n, "stall_done", b.stall_req, 0);
    chk(n, "stall_cycles", stl, v.lat);
    @(posedge clk); #1;
    chk(n, "done_1cyc", b.done, 0);
    chk(n, "idle_after", b.busy, 0);
    chk(n, "hi_held", b.hi_out, v.hi);
  endtask
  initial begin
    int lat, seen;
    vt[0]  = '{3'd0, 32'hFFFFFFFE, 32'd3,        32'd0, 32'd0,        32'hFFFFFFFF, 32'hFFFFFFFA, 1'b0, 33};
    vt[1]  = '{3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0, 32'd0,        32'hFFFFFFFE, 32'h00000001, 1'b0, 33};
    vt[2]  = '{3'd2, 32'hFFFFFFF9, 32'd2,        32'd0, 32'd0,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 33};
    vt[3]  = '{3'd3, 32'h12345678, 32'd0,        32'd0, 32'd0,        32'h12345678, 32'hFFFFFFFF, 1'b1, 2};
    vt[4]  = '{3'd4, 32'd1,        32'd1,        32'd0, 32'hFFFFFFFF, 32'd1,        32'd0,        1'b0, 33};
    vt[5]  = '{3'd5, 32'd1,        32'd1,        32'd0, 32'hFFFFFFFF, 32'd0,        32'hFFFFFFFE, 1'b0, 33};
    vt[6]  = '{3'd2, 32'h80000000, 32'hFFFFFFFF, 32'd0, 32'd0,        32'd0,        32'h80000000, 1'b0, 33};
    vt[7]  = '{3'd3, 32'd100,      32'd7,        32'd0, 32'd0,        32'd2,        32'd14,       1'b0, 33};
    vt[8]  = '{3'd2, 32'd7,        32'hFFFFFFFE, 32'd0, 32'd0,        32'd1,        32'hFFFFFFFD, 1'b0, 33};
    vt[9]  = '{3'd2, 32'hFFFFFFF0, 32'd0,        32'd0, 32'd0,        32'hFFFFFFF0, 32'hFFFFFFFF, 1'b1, 2};
    vt[10] = '{3'd4, 32'hFFFFFFFE, 32'd3,        32'd0, 32'd5,        32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 33};
    vt[11] = '{3'd1, 32'h00010000, 32'h00010000, 32'd0, 32'd0,        32'd1,        32'd0,        1'b0, 33};
    vt[12] = '{3'd5, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0, 32'd0,        32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 33};
    b.start = 1'b1; b.op = 3'd0; b.op1 = 32'd2; b.op2 = 32'd3; b.hi_in = '0; b.lo_in = '0; b.cancel = 1'b0;
    b0.start = 1'b0; b0.op = 3'd0; b0.op1 = '0; b0.op2 = '0; b0.hi_in = '0; b0.lo_in = '0; b0.cancel = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset", "stall", b.stall_req, 0);
    chk("reset", "busy", b.busy, 0);
    chk("reset", "done", b.done, 0);
    chk("reset", "hilo_wen", b.hilo_wen, 0);
    chk("reset", "hi", b.hi_out, 0);
    chk("reset", "lo", b.lo_out, 0);
    chk("reset", "dz", b.div_zero, 0);
    b.start = 1'b0; rst_n = 1'b1;
    @(posedge clk); #1;
    chk("reset", "start_ignored", b.busy, 0);
    b.op = 3'b110; b.start = 1'b1;
    #1;
    chk("reserved", "stall", b.stall_req, 0);
    @(posedge clk); #1;
    chk("reserved", "busy", b.busy, 0);
    b.op = 3'd0; b.cancel = 1'b1;
    #1;
    chk("cancel_start", "stall", b.stall_req, 0);
    @(posedge clk); #1;
    chk("cancel_start", "busy", b.busy, 0);
    b.start = 1'b0; b.cancel = 1'b0;
    for (int i = 0; i < 13; i++) run_op(vt[i], $sformatf("vec%0d", i));
    b.op = 3'd1; b.op1 = 32'd5; b.op2 = 32'd7; b.start = 1'b1;
    @(posedge clk); #1;
    b.op = 3'd3; b.op1 = 32'hFFFF; b.op2 = 32'd0;
    repeat (4) @(posedge clk);
    #1;
    b.start = 1'b0;
    lat = 5;
    while (!b.done && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("busy_start", "latency", lat, 33);
    chk("busy_start", "lo", b.lo_out, 32'd35);
    chk("busy_start", "hi", b.hi_out, 0);
    @(posedge clk); #1;
    b.op = 3'd2; b.op1 = 32'd100; b.op2 = 32'd7; b.start = 1'b1;
    @(posedge clk); #1;
    b.start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    b.cancel = 1'b1;
    @(posedge clk); #1;
    b.cancel = 1'b0;
    chk("cancel", "busy", b.busy, 0);
    seen = 0;
    repeat (40) begin
      seen |= int'(b.done);
      @(posedge clk); #1;
    end
    chk("cancel", "no_done", seen, 0);
    run_op(vt[7], "after_cancel");
    b.op = 3'd1; b.op1 = 32'd5; b.op2 = 32'd7; b.start = 1'b1;
    @(posedge clk); #1;
    b.start = 1'b0;
    repeat (14) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("mid_reset", "hi", b.hi_out, 0);
    chk("mid_reset", "lo", b.lo_out, 0);
    chk("mid_reset", "busy", b.busy, 0);
    chk("mid_reset", "stall", b.stall_req, 0);
    chk("mid_reset", "done", b.done, 0);
    chk("mid_reset", "dz", b.div_zero, 0);
    rst_n = 1'b1;
    seen = 0;
    repeat (40) begin
      seen |= int'(b.done);
      @(posedge clk); #1;
    end
    chk("mid_reset", "no_done", seen, 0);
    b0.op = 3'd0; b0.op1 = 32'hFFFFFFFE; b0.op2 = 32'd3; b0.start = 1'b1;
    #1;
    chk("single", "stall_start", b0.stall_req, 1);
    @(posedge clk); #1;
    b0.start = 1'b0;
    lat = 1;
    while (!b0.done && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("single", "latency", lat, 2);
    chk("single", "hi", b0.hi_out, 32'hFFFFFFFF);
    chk("single", "lo", b0.lo_out, 32'hFFFFFFFA);
    @(posedge clk); #1;
    b0.op = 3'd4; b0.lo_in = 32'd5; b0.start = 1'b1;
    @(posedge clk); #1;
    b0.start = 1'b0;
    @(posedge clk); #1;
    chk("single_madd", "done", b0.done, 1);
    chk("single_madd", "hi", b0.hi_out, 32'hFFFFFFFF);
    chk("single_madd", "lo", b0.lo_out, 32'hFFFFFFFF);
    @(posedge clk); #1;
    b0.op = 3'd1; b0.op1 = 32'd2; b0.op2 = 32'd3; b0.start = 1'b1;
    @(posedge clk); #1;
    b0.start = 1'b0;
    @(posedge clk); #1;
    b0.cancel = 1'b1;
    #1;
    chk("cancel_done", "done", b0.done, 0);
    chk("cancel_done", "hilo_wen", b0.hilo_wen, 0);
    @(posedge clk); #1;
    b0.cancel = 1'b0;
    chk("cancel_done", "busy", b0.busy, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule
